// File: rtl/mod_pkg.sv
// Shared definitions for the sequential modular multiply-accumulate unit:
// default modulus, operand width helper and the control FSM state type.
package mod_pkg;
  localparam int MOD_DEFAULT = 47;

  function automatic int w_of(input int mod);
    return $clog2(mod);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mod_csub.sv
// Conditional subtract: folds a value in [0, 2*MOD) back into [0, MOD).
module mod_csub
  import mod_pkg::*;
#(
  parameter  int MOD = MOD_DEFAULT,
  localparam int W   = w_of(MOD)
) (
  input  logic [W:0]   x,
  output logic [W-1:0] y
);
  localparam logic [W:0] MODV = (W+1)'(MOD);

  logic [W:0] diff;

  assign diff = x - MODV;

  always_comb begin
    y = x[W-1:0];
    if (x >= MODV) y = diff[W-1:0];
  end
endmodule

// File: rtl/mod_mac_seq.sv
// Sequential (a*b + c) mod MOD: MSB-first shift-and-add over the multiplier,
// one bit per cycle, with valid/ready on the operand and result sides.
module mod_mac_seq
  import mod_pkg::*;
#(
  parameter  int MOD = MOD_DEFAULT,
  localparam int W   = w_of(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err,
  output logic         busy
);
  localparam int         CW   = $clog2(W);
  localparam logic [W:0] MODV = (W+1)'(MOD);

  state_t         state, nxt;
  logic [W-1:0]   a_q, b_q, c_q, acc;
  logic [CW-1:0]  cnt;
  logic           err_q;
  logic           in_err;
  logic [W-1:0]   dbl_r, add_r, fin_r, step;
  logic [W:0]     add_sum, fin_sum;

  assign in_err = ({1'b0, in_a} >= MODV) || ({1'b0, in_b} >= MODV) ||
                  ({1'b0, in_c} >= MODV);

  // acc < MOD keeps every intermediate sum below 2*MOD, so one fold suffices.
  mod_csub #(.MOD(MOD)) u_dbl (.x({acc, 1'b0}), .y(dbl_r));

  assign add_sum = {1'b0, dbl_r} + {1'b0, a_q};
  mod_csub #(.MOD(MOD)) u_add (.x(add_sum), .y(add_r));

  assign fin_sum = {1'b0, acc} + {1'b0, c_q};
  mod_csub #(.MOD(MOD)) u_fin (.x(fin_sum), .y(fin_r));

  assign step = b_q[cnt] ? add_r : dbl_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Out-of-range operands skip MUL and go through FIN so the result
  // registers are only ever written in one place.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) nxt = in_err ? ST_FIN : ST_MUL;
      end
      ST_MUL:  if (cnt == '0) nxt = ST_FIN;
      ST_FIN:  nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      out_res <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          c_q   <= in_c;
          err_q <= in_err;
          acc   <= '0;
          cnt   <= CW'(W-1);
        end
        ST_MUL: begin
          acc <= step;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        ST_FIN: begin
          out_res <= err_q ? '0 : fin_r;
          out_err <= err_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mod_mac_seq.md
Name: mod_mac_seq

Overview:
- Parametrised sequential modular multiply-accumulate unit: computes (a*b + c) mod MOD with MSB-first shift-and-add (Horner) iteration, one multiplier bit per cycle.
- Successor to the fixed mod-47, 6-bit combinational residue tables: any modulus, derived width, registered datapath, valid/ready handshakes on both sides.
- Sits between the residue-conversion tables and the downstream residue accumulators in the modular calculator datapath.

Parameters:
- MOD, 47, modulus; must be >= 3.
- W, $clog2(MOD), operand/result width; derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  unit can accept an operand set.
- in_a  in  W  multiplicand, legal range 0..MOD-1.
- in_b  in  W  multiplier, legal range 0..MOD-1.
- in_c  in  W  addend, legal range 0..MOD-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_res  out  W  (a*b + c) mod MOD; 0 when out_err=1.
- out_err  out  1  operand out of range.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_res=0; out_err=0; busy=0; acc, cnt, operand registers = 0.
- FSM states: IDLE, MUL, FIN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch a, b, c.
  - Any operand >= MOD: go to DONE with out_err=1, out_res=0.
  - Otherwise: acc=0, cnt=W-1, go to MUL.
- MUL, one step per cycle:
  - t = 2*acc; if t >= MOD then t -= MOD.
  - If b[cnt] = 1: t += a; if t >= MOD then t -= MOD.
  - acc = t.
  - cnt==0 -> FIN; otherwise cnt -= 1.
  - Internal arithmetic is W+1 bits. acc < MOD holds after every step.
- FIN: t = acc + c; if t >= MOD then t -= MOD. out_res=t, out_err=0, go to DONE.
- DONE: out_valid=1; out_res and out_err held stable. On out_ready: out_valid=0, go to IDLE.
- in_ready is 0 in MUL, FIN and DONE. No overlap of operations.
  - Minimum initiation interval for valid operands: W+3 cycles (W MUL steps, FIN, DONE handshake, IDLE accept).
- Latency (valid operands): accept on edge E; out_valid rises after edge E+W+1 (7 cycles for MOD=47).
- Latency (error): out_valid rises after edge E+1.
- Backpressure: out_ready may be held low indefinitely; outputs hold. out_ready while out_valid=0 is ignored.
- in_valid dropped while in_ready=0 has no effect. Operands are sampled only on the accept edge.
- b=0 or a=0: result = c. MOD with W = $clog2(MOD) exactly (e.g. 64): all code points legal except none >= MOD; logic still correct.
- Reset mid-operation: in-flight result discarded, no out_valid produced, outputs return to reset values immediately.

Decomposition:
- Shared package mod_pkg:
  - default modulus constant MOD_DEFAULT=47.
  - width function w_of(mod).
  - FSM state enum type.
- Sub-module mod_csub (combinational): input W+1-bit value < 2*MOD; output the value minus MOD if >= MOD, W bits.
  - Three instances: doubling reduction, add reduction, final addend reduction.

Test Plan:
- MOD=47: a=5, b=7, c=0 -> out_res=35, out_err=0; out_valid exactly 7 cycles after accept.
- MOD=47: a=46, b=46, c=46 -> out_res=0 (2116+46=2162=46*47).
- MOD=47: a=12, b=4, c=3 -> 51 mod 47 = 4. Then hold out_ready=0 for 10 cycles: out_valid, out_res=4 held, in_ready=0 throughout. Release -> accepts next operand set the following cycle.
- MOD=47: a=47, b=1, c=0 -> out_err=1, out_res=0, out_valid one cycle after accept. Second vector c=63 -> same error response.
- Reset: assert rst_n=0 three cycles into an operation -> out_valid=0, in_ready=1 immediately. After release, a=3, b=3, c=1 -> 10.
- MOD=97 (W=7), random 1000 vectors against reference model, back-to-back in_valid -> all match; accepts spaced >= W+3 cycles.
